// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline hazard controller. Detects load-use hazards, handles
//            MEM-stage redirects, and sequences interrupt entry and return.
//            Also keeps a saturating stall counter and a wrapping IRQ counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_valid,
    input  logic        ex_memread,
    input  logic [4:0]  ex_wreg,
    input  logic        mem_redirect,
    input  logic        irq_req,
    input  logic        kernel_mode,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        irq_take,
    output logic [15:0] stall_cnt,
    output logic [7:0]  irq_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_IRQ_PEND = 2'd1,
        S_IRQ_SVC  = 2'd2
    } state_t;

    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_seen_kernel;
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_irq_cnt;
    logic        w_lu;
    logic        w_stall;
    logic        w_take;

    // Register 0 is hard-wired, so a load targeting it can never create a hazard.
    assign w_lu = ex_memread && (ex_wreg != 5'd0) &&
                  ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

    // A redirect squashes the dependent instruction anyway, so no stall is needed.
    assign w_stall = w_lu && !mem_redirect;

    // The ID instruction is marked for the interrupt only when it is real and will not be stalled or squashed.
    assign w_take  = (r_state == S_IRQ_PEND) && id_valid && !mem_redirect &&
                     !w_lu && !kernel_mode;

    // State register and handler-entry tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_RUN;
            r_seen_kernel <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_seen_kernel <= (w_next_state == S_IRQ_SVC) &&
                             (r_seen_kernel || kernel_mode);
        end
    end

    // Next-state logic for the interrupt sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (irq_req && !kernel_mode)
                    w_next_state = S_IRQ_PEND;
            end
            S_IRQ_PEND: begin
                if (w_take)
                    w_next_state = S_IRQ_SVC;
                else if (kernel_mode || !irq_req)
                    w_next_state = S_RUN;
            end
            S_IRQ_SVC: begin
                // Interrupts stay masked until the handler has been entered and left.
                if (r_seen_kernel && !kernel_mode)
                    w_next_state = S_RUN;
            end
            default: w_next_state = S_RUN;
        endcase
    end

    // Pipeline write-enable, flush and interrupt-take outputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        irq_take    = 1'b0;
        if (reset) begin
            if (mem_redirect) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (w_lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
            end else if (w_take) begin
                // The marked instruction proceeds; the one behind it is squashed.
                irq_take    = 1'b1;
                ifid_flush  = 1'b1;
            end
        end
    end

    // Event counters: stalls saturate, interrupts wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
            r_irq_cnt   <= 8'd0;
        end else begin
            if (w_stall && (r_stall_cnt != c_STALL_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_take)
                r_irq_cnt <= r_irq_cnt + 8'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign irq_cnt   = r_irq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_valid;
    logic        ex_memread;
    logic [4:0]  ex_wreg;
    logic        mem_redirect;
    logic        irq_req;
    logic        kernel_mode;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        irq_take;
    logic [15:0] stall_cnt;
    logic [7:0]  irq_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_valid     (id_valid),
        .ex_memread   (ex_memread),
        .ex_wreg      (ex_wreg),
        .mem_redirect (mem_redirect),
        .irq_req      (irq_req),
        .kernel_mode  (kernel_mode),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .irq_take     (irq_take),
        .stall_cnt    (stall_cnt),
        .irq_cnt      (irq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pack the five pipeline controls: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}.
    function automatic logic [31:0] ctl();
        return {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush};
    endfunction

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_valid = 1'b0;
        ex_memread = 1'b0; ex_wreg = 5'd0; mem_redirect = 1'b0;
        irq_req = 1'b0; kernel_mode = 1'b0;
    endtask

    // One full interrupt round trip starting and ending in RUN.
    task automatic take_once();
        irq_req = 1'b1; kernel_mode = 1'b0; id_valid = 1'b1;
        tick();
        tick();
        irq_req = 1'b0; kernel_mode = 1'b1;
        tick();
        kernel_mode = 1'b0;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        // Load-use inputs applied during reset must not stall.
        ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8;
        #1;
        chk("rst_ctl", ctl(), 32'b11000);
        chk("rst_irq_take", {31'd0, irq_take}, 32'd0);
        tick();
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_irq_cnt", {24'd0, irq_cnt}, 32'd0);
        idle();
        reset = 1'b1;
        #1;
        chk("idle_ctl", ctl(), 32'b11000);

        // Load-use through rs.
        ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8;
        #1;
        chk("lu_rs_ctl", ctl(), 32'b00010);
        tick(); exp_stall++;
        idle();
        #1;
        chk("lu_rs_cnt", {16'd0, stall_cnt}, exp_stall);

        // Load-use through rt, only when rt is used.
        ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        chk("rt_unused_ctl", ctl(), 32'b11000);
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_ctl", ctl(), 32'b00010);
        tick(); exp_stall++;
        chk("lu_rt_cnt", {16'd0, stall_cnt}, exp_stall);

        // Redirect overrides load-use.
        mem_redirect = 1'b1;
        #1;
        chk("redir_ctl", ctl(), 32'b11111);
        tick();
        chk("redir_cnt", {16'd0, stall_cnt}, exp_stall);

        // Register 0 never hazardous; no load never hazardous.
        idle();
        ex_memread = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0;
        #1;
        chk("r0_ctl", ctl(), 32'b11000);
        ex_memread = 1'b0; ex_wreg = 5'd5; id_rs = 5'd5;
        #1;
        chk("noload_ctl", ctl(), 32'b11000);
        tick();
        chk("noload_cnt", {16'd0, stall_cnt}, exp_stall);

        // Interrupt: id_valid low for two cycles, then take on the third.
        idle();
        irq_req = 1'b1; kernel_mode = 1'b0; id_valid = 1'b0;
        #1;
        chk("irq_c1", {31'd0, irq_take}, 32'd0);
        tick();
        chk("irq_c2", {31'd0, irq_take}, 32'd0);
        tick();
        id_valid = 1'b1;
        #1;
        chk("irq_c3", {31'd0, irq_take}, 32'd1);
        chk("irq_c3_ctl", ctl(), 32'b11100);
        tick();
        chk("irq_cnt1", {24'd0, irq_cnt}, 32'd1);
        chk("svc_mask", {31'd0, irq_take}, 32'd0);

        // Handler runs in kernel mode for 10 cycles with irq_req held.
        kernel_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("svc_kernel", {31'd0, irq_take}, 32'd0);
            tick();
        end
        kernel_mode = 1'b0;
        #1;
        chk("svc_ret", {31'd0, irq_take}, 32'd0);
        tick();
        chk("run_again", {31'd0, irq_take}, 32'd0);
        tick();
        chk("second_take", {31'd0, irq_take}, 32'd1);
        tick();
        chk("irq_cnt2", {24'd0, irq_cnt}, 32'd2);
        irq_req = 1'b0; kernel_mode = 1'b1;
        tick();
        kernel_mode = 1'b0;
        tick();

        // Pending request withdrawn before it can be taken.
        irq_req = 1'b1; id_valid = 1'b0;
        tick();
        irq_req = 1'b0;
        tick();
        id_valid = 1'b1;
        #1;
        chk("withdrawn", {31'd0, irq_take}, 32'd0);
        tick();
        chk("withdrawn_cnt", {24'd0, irq_cnt}, 32'd2);

        // Take deferred by a load-use stall while pending.
        irq_req = 1'b1; id_valid = 1'b1;
        tick();
        ex_memread = 1'b1; ex_wreg = 5'd9; id_rs = 5'd9;
        #1;
        chk("pend_lu_take", {31'd0, irq_take}, 32'd0);
        chk("pend_lu_ctl", ctl(), 32'b00010);
        tick(); exp_stall++;
        ex_memread = 1'b0;
        #1;
        chk("pend_after_lu", {31'd0, irq_take}, 32'd1);
        tick();
        chk("pend_lu_cnts", {8'd0, stall_cnt, irq_cnt}, {8'd0, exp_stall[15:0], 8'd3});
        irq_req = 1'b0; kernel_mode = 1'b1;
        tick();
        kernel_mode = 1'b0;
        tick();

        // Reset in the middle of IRQ_PEND.
        idle();
        irq_req = 1'b1;
        tick();
        #1;
        id_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_pend_take", {31'd0, irq_take}, 32'd0);
        chk("rst_pend_cnt", {24'd0, irq_cnt}, 32'd0);
        tick();
        irq_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_rst_take", {31'd0, irq_take}, 32'd0);
            tick();
        end

        // irq_cnt wraps after 256 takes.
        idle();
        for (int i = 0; i < 255; i++) take_once();
        chk("irq_cnt_ff", {24'd0, irq_cnt}, 32'hFF);
        take_once();
        chk("irq_cnt_wrap", {24'd0, irq_cnt}, 32'h00);

        // stall_cnt saturates.
        idle();
        ex_memread = 1'b1; ex_wreg = 5'd4; id_rs = 5'd4;
        for (int i = 0; i < 70000; i++) tick();
        chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
        tick();
        chk("stall_hold", {16'd0, stall_cnt}, 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
